cam_strip_sched: RTL
====================

# cam_strip_sched

Strip scheduler between the camera capture path and the JPEG encoder core. It tracks 8-line strips completed in the 16-line camera buffer (two strip slots), issues one encode-start per strip to the encoder in capture order, and detects camera-overrun of unconsumed slots. It also drives `encoder_active` back to the camera capture block, gating capture to whole frames.

## Interface
Parameters:
- `W_PH`, 11, MSB index of picture height (height is `W_PH+1` bits).
- `W_STRIP`, 8, MSB index of strip counters.

Ports:
- `clk`  in  1  main encoder clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enc_enable_i`  in  1  software run enable; sampled level.
- `PicHeight_i`  in  W_PH+1  picture height in lines, static during a frame.
- `cam_pic_start_f`  in  1  one-cycle pulse: first line of a new camera frame is being written.
- `camfifo_o_f`  in  1  one-cycle pulse: a strip (8 lines, or the final partial strip) is complete in the buffer.
- `enc_strip_done_f`  in  1  one-cycle pulse: encoder finished reading the current strip.
- `encoder_active`  out  1  capture enable to camera block.
- `enc_pic_start_f`  out  1  one-cycle pulse: frame encode begins.
- `enc_strip_start_f`  out  1  one-cycle pulse: encoder may read the strip in `enc_strip_sel`.
- `enc_strip_sel`  out  1  buffer slot (0 = lines 0-7, 1 = lines 8-15) of the issued strip.
- `enc_pic_end_f`  out  1  one-cycle pulse: last strip of frame consumed.
- `overflow_o`  out  1  sticky: camera completed a strip while both slots were full.
- `strip_idx_o`  out  W_STRIP+1  index of the strip currently being encoded.

## Operation
- Strips per frame: `n_strip = (PicHeight_i + 7) >> 3`, registered at `cam_pic_start_f` accept.
- States: IDLE, WAIT_PIC, WAIT_STRIP, ENCODE, PIC_END.
- IDLE: `encoder_active`=0. `enc_enable_i`=1 -> WAIT_PIC, `encoder_active`<=1.
- WAIT_PIC: on `cam_pic_start_f` -> WAIT_STRIP; clear occupancy, write slot, read slot, `strip_idx_o`, write count; pulse `enc_pic_start_f`. If `enc_enable_i`=0 here -> IDLE.
- Occupancy `occ` (0..2): +1 on `camfifo_o_f`, -1 on `enc_strip_done_f`; both same cycle -> unchanged. Write slot toggles on each `camfifo_o_f`; read slot toggles on each `enc_strip_done_f`.
- Write strips beyond `n_strip` in a frame are ignored (no `occ` change).
- WAIT_STRIP: when `occ`>0 (registered value) -> ENCODE, pulse `enc_strip_start_f` with `enc_strip_sel`=read slot.
- ENCODE: on `enc_strip_done_f`: `strip_idx_o`+1; if it was strip `n_strip-1` -> PIC_END, else WAIT_STRIP.
- PIC_END: pulse `enc_pic_end_f` once; if `enc_enable_i`=1 -> WAIT_PIC, else IDLE with `encoder_active`<=0.
- Overflow: `camfifo_o_f` while `occ`==2 and no simultaneous done -> `overflow_o`<=1 (sticky until `rst`), abort frame: -> WAIT_PIC, `occ`<=0, no `enc_pic_end_f`.
- `enc_strip_done_f` outside ENCODE ignored. `cam_pic_start_f` outside WAIT_PIC/IDLE ignored.

## Timing
- Reset values: `encoder_active`=0, all pulses 0, `enc_strip_sel`=0, `overflow_o`=0, `strip_idx_o`=0, state IDLE, `occ`=0.
- All outputs registered.
- `camfifo_o_f` at cycle T with `occ`=0 in WAIT_STRIP -> `enc_strip_start_f` at T+2.
- `enc_strip_done_f` at T with next strip already buffered -> next `enc_strip_start_f` at T+2.
- `enc_pic_end_f` at T+1 after final `enc_strip_done_f` at T-1 (i.e. two cycles after done).
- `rst` mid-frame: all state returns to reset values next cycle; no pulses issued in that cycle.

## Test plan
- Height 32, `enc_enable_i`=1, pic start, 4 strip pulses spaced 100 cycles, done 20 cycles after each start -> 4 starts with sel 0,1,0,1; `strip_idx_o` 0..3; one `enc_pic_end_f`; `overflow_o`=0.
- Height 20 -> `n_strip`=3; 3 starts; a 4th `camfifo_o_f` ignored; pic end after 3rd done.
- Back-to-back: 2 strip pulses while encoder busy, 3rd pulse same cycle as done -> no overflow, `occ` stays 2, starts in order with correct sel.
- Overrun: 3 strip pulses with no done -> `overflow_o`=1, state WAIT_PIC, next frame encodes normally, `overflow_o` stays 1.
- Drop `enc_enable_i` mid-frame -> frame completes, `enc_pic_end_f`, then `encoder_active`=0 in IDLE.
- Assert `rst` during ENCODE -> next cycle all outputs at reset values; re-enable runs a clean frame.

Source files
------------

// File: rtl/cam_strip_sched.sv
// cam_strip_sched: hands camera-buffer strips (two 8-line slots) to the JPEG
// encoder in capture order, tracks slot occupancy and flags camera overrun.
module cam_strip_sched #(
  parameter int unsigned W_PH    = 11,
  parameter int unsigned W_STRIP = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enc_enable_i,
  input  logic [W_PH:0]      PicHeight_i,
  input  logic               cam_pic_start_f,
  input  logic               camfifo_o_f,
  input  logic               enc_strip_done_f,
  output logic               encoder_active,
  output logic               enc_pic_start_f,
  output logic               enc_strip_start_f,
  output logic               enc_strip_sel,
  output logic               enc_pic_end_f,
  output logic               overflow_o,
  output logic [W_STRIP:0]   strip_idx_o
);

  localparam int unsigned PH_W  = W_PH + 1;
  localparam int unsigned ST_W  = W_STRIP + 1;
  localparam int unsigned SUM_W = PH_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PIC,
    S_WAIT_STRIP,
    S_ENCODE,
    S_PIC_END
  } state_t;

  state_t            r_state;
  logic              r_active;
  logic              r_pic_start;
  logic              r_strip_start;
  logic              r_strip_sel;
  logic              r_pic_end;
  logic              r_overflow;
  logic [ST_W-1:0]   r_strip_idx;
  logic [ST_W-1:0]   r_n_strip;
  logic [ST_W-1:0]   r_wr_cnt;
  logic [1:0]        r_occ;
  logic              r_wr_slot;
  logic              r_rd_slot;

  logic [SUM_W-1:0]  w_ph_sum;
  logic [ST_W-1:0]   w_n_strip;
  logic              w_in_frame;
  logic              w_wr;
  logic              w_rd;
  logic              w_ovf;
  logic              w_last;

  // Strip count of the incoming frame, rounded up to whole strips.
  assign w_ph_sum  = SUM_W'(PicHeight_i) + SUM_W'(7);
  assign w_n_strip = ST_W'(w_ph_sum >> 3);

  // Qualified buffer events: writes only count inside a frame and up to n_strip,
  // reads only while a strip is being encoded.
  assign w_in_frame = (r_state == S_WAIT_STRIP) || (r_state == S_ENCODE) ||
                      (r_state == S_PIC_END);
  assign w_wr   = camfifo_o_f && w_in_frame && (r_wr_cnt < r_n_strip);
  assign w_rd   = enc_strip_done_f && (r_state == S_ENCODE);
  assign w_ovf  = w_wr && (r_occ == 2'd2) && !w_rd;
  assign w_last = (r_strip_idx + ST_W'(1)) == r_n_strip;

  // Scheduler FSM, occupancy tracking and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_active      <= 1'b0;
      r_pic_start   <= 1'b0;
      r_strip_start <= 1'b0;
      r_strip_sel   <= 1'b0;
      r_pic_end     <= 1'b0;
      r_overflow    <= 1'b0;
      r_strip_idx   <= '0;
      r_n_strip     <= '0;
      r_wr_cnt      <= '0;
      r_occ         <= 2'd0;
      r_wr_slot     <= 1'b0;
      r_rd_slot     <= 1'b0;
    end else begin
      r_pic_start   <= 1'b0;
      r_strip_start <= 1'b0;
      r_pic_end     <= 1'b0;

      if (w_wr) begin
        r_wr_slot <= ~r_wr_slot;
        r_wr_cnt  <= r_wr_cnt + ST_W'(1);
      end
      if (w_rd) begin
        r_rd_slot <= ~r_rd_slot;
      end
      if (w_wr && !w_rd) begin
        r_occ <= r_occ + 2'd1;
      end else if (w_rd && !w_wr) begin
        r_occ <= r_occ - 2'd1;
      end

      if (w_ovf) begin
        // Camera overwrote an unconsumed slot: drop the frame, wait for the next.
        r_overflow <= 1'b1;
        r_occ      <= 2'd0;
        r_state    <= S_WAIT_PIC;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (enc_enable_i) begin
              r_state  <= S_WAIT_PIC;
              r_active <= 1'b1;
            end
          end
          S_WAIT_PIC: begin
            if (!enc_enable_i) begin
              r_state  <= S_IDLE;
              r_active <= 1'b0;
            end else if (cam_pic_start_f) begin
              r_state     <= S_WAIT_STRIP;
              r_pic_start <= 1'b1;
              r_n_strip   <= w_n_strip;
              r_occ       <= 2'd0;
              r_wr_slot   <= 1'b0;
              r_rd_slot   <= 1'b0;
              r_strip_idx <= '0;
              r_wr_cnt    <= '0;
            end
          end
          S_WAIT_STRIP: begin
            if (r_occ != 2'd0) begin
              r_state       <= S_ENCODE;
              r_strip_start <= 1'b1;
              r_strip_sel   <= r_rd_slot;
            end
          end
          S_ENCODE: begin
            if (w_rd) begin
              r_strip_idx <= r_strip_idx + ST_W'(1);
              r_state     <= w_last ? S_PIC_END : S_WAIT_STRIP;
            end
          end
          S_PIC_END: begin
            r_pic_end <= 1'b1;
            if (enc_enable_i) begin
              r_state <= S_WAIT_PIC;
            end else begin
              r_state  <= S_IDLE;
              r_active <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign encoder_active    = r_active;
  assign enc_pic_start_f   = r_pic_start;
  assign enc_strip_start_f = r_strip_start;
  assign enc_strip_sel     = r_strip_sel;
  assign enc_pic_end_f     = r_pic_end;
  assign overflow_o        = r_overflow;
  assign strip_idx_o       = r_strip_idx;

endmodule
